pixel_write_sink: RTL and testbench

Avalon-MM write-only slave that terminates the GPU pixel master port (address / 16-bit writedata / write / waitrequest). It decodes each pixel write address into a row/column framebuffer index and buffers accepted pixels in a small FIFO. A drain FSM writes them to a single-port framebuffer with ready/valid flow control. It rejects out-of-window addresses, counts traffic, and pulses on completion of the last pixel of a frame.

---
 rtl/pixel_write_sink.sv | 211 +++++++++++++++++++++
 tb/tb_pixel_write_sink.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_sink.sv
// Avalon-MM write-only pixel sink. Decodes pixel addresses into framebuffer
// indices, buffers accepted pixels in a small circular FIFO and drains them
// to a single-port framebuffer through a ready/valid handshake. Rejected
// writes are counted and latched into a sticky error flag.
module pixel_write_sink #(
    parameter int          H_RESOLUTION = 320,
    parameter int          V_RESOLUTION = 240,
    parameter int          PIXEL_BITS   = 16,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          ROW_BITS     = $clog2(V_RESOLUTION),
    parameter int          COL_BITS     = $clog2(H_RESOLUTION)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [31:0]                  s_address,
    input  logic [PIXEL_BITS-1:0]        s_writedata,
    input  logic                         s_write,
    output logic                         s_waitrequest,
    output logic [ROW_BITS+COL_BITS-1:0] fb_addr,
    output logic [PIXEL_BITS-1:0]        fb_data,
    output logic                         fb_we,
    input  logic                         fb_ready,
    input  logic                         clear,
    output logic [31:0]                  pixel_count,
    output logic [15:0]                  drop_count,
    output logic                         error,
    output logic                         frame_done
);

    localparam int ADDR_W = ROW_BITS + COL_BITS;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(V_RESOLUTION * H_RESOLUTION - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Saturating increment used for the drop counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Address decode
    logic [31:0]         off;
    logic [ROW_BITS-1:0] dec_row;
    logic [COL_BITS-1:0] dec_col;
    logic                dec_valid;
    logic [ADDR_W-1:0]   dec_index;

    // FIFO storage and control
    logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
    logic [PIXEL_BITS-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  fifo_full, fifo_empty;
    logic                  accept, push, drop, pop;

    // Drain FSM and framebuffer output registers
    state_t                state_q, state_d;
    logic                  fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]     fb_addr_q, fb_addr_d;
    logic [PIXEL_BITS-1:0] fb_data_q, fb_data_d;
    logic                  handshake;

    // Statistics
    logic [31:0] pixel_count_q, pixel_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic        error_q, error_d;
    logic        frame_done_q, frame_done_d;

    assign fifo_full     = (count_q == FULL_CNT);
    assign fifo_empty    = (count_q == '0);
    assign s_waitrequest = reset | fifo_full;
    assign accept        = s_write & ~s_waitrequest;
    assign push          = accept & dec_valid;
    assign drop          = accept & ~dec_valid;
    assign handshake     = fb_we_q & fb_ready;

    // Split the byte offset into row/column and check it lies in the window.
    always_comb begin
        off       = s_address - BASE_ADDRESS;
        dec_row   = off[COL_BITS+1 +: ROW_BITS];
        dec_col   = off[1 +: COL_BITS];
        dec_valid = (off[0] == 1'b0)
                 && ((off >> (ROW_BITS + COL_BITS + 1)) == 32'd0)
                 && ({{(32-COL_BITS){1'b0}}, dec_col} < 32'(H_RESOLUTION))
                 && ({{(32-ROW_BITS){1'b0}}, dec_row} < 32'(V_RESOLUTION));
        dec_index = ADDR_W'(dec_row) * ADDR_W'(H_RESOLUTION) + ADDR_W'(dec_col);
    end

    // Drain FSM: load the FIFO head into the output registers and hold it
    // until the framebuffer accepts; chain back-to-back when more is queued.
    always_comb begin
        state_d      = state_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        pop          = 1'b0;
        frame_done_d = handshake && (fb_addr_q == LAST_IDX);
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fb_addr_d = fifo_addr_q[rd_ptr_q];
                    fb_data_d = fifo_data_q[rd_ptr_q];
                    fb_we_d   = 1'b1;
                    pop       = 1'b1;
                    state_d   = WRITE;
                end
            end
            WRITE: begin
                if (fb_ready) begin
                    if (!fifo_empty) begin
                        fb_addr_d = fifo_addr_q[rd_ptr_q];
                        fb_data_d = fifo_data_q[rd_ptr_q];
                        fb_we_d   = 1'b1;
                        pop       = 1'b1;
                    end else begin
                        fb_we_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                fb_we_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy bookkeeping; push and pop may coincide.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Traffic counters and sticky error; clear overrides any update.
    always_comb begin
        pixel_count_d = pixel_count_q;
        drop_count_d  = drop_count_q;
        error_d       = error_q;
        if (clear) begin
            pixel_count_d = '0;
            drop_count_d  = '0;
            error_d       = 1'b0;
        end else begin
            if (handshake) begin
                pixel_count_d = pixel_count_q + 32'd1;
            end
            if (drop) begin
                drop_count_d = sat_inc16(drop_count_q);
                error_d      = 1'b1;
            end
        end
    end

    // FIFO payload storage; contents are only meaningful between the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= dec_index;
            fifo_data_q[wr_ptr_q] <= s_writedata;
        end
    end

    // State, pointer, output and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            pixel_count_q <= '0;
            drop_count_q  <= '0;
            error_q       <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            pixel_count_q <= pixel_count_d;
            drop_count_q  <= drop_count_d;
            error_q       <= error_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_data     = fb_data_q;
    assign pixel_count = pixel_count_q;
    assign drop_count  = drop_count_q;
    assign error       = error_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_pixel_write_sink.sv
// Directed bench for pixel_write_sink with a queue-based reference model.
module tb_pixel_write_sink;

    localparam int H     = 320;
    localparam int V     = 240;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] s_address;
    logic [15:0] s_writedata;
    logic        s_write;
    logic        s_waitrequest;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        fb_we;
    logic        fb_ready;
    logic        clear;
    logic [31:0] pixel_count;
    logic [15:0] drop_count;
    logic        error;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    pixel_write_sink dut (
        .clock        (clock),
        .reset        (reset),
        .s_address    (s_address),
        .s_writedata  (s_writedata),
        .s_write      (s_write),
        .s_waitrequest(s_waitrequest),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .fb_ready     (fb_ready),
        .clear        (clear),
        .pixel_count  (pixel_count),
        .drop_count   (drop_count),
        .error        (error),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pixels waiting in a queue plus the one on the bus.
    logic [32:0] mq[$];
    logic        m_we  = 1'b0;
    logic [16:0] m_addr = '0;
    logic [15:0] m_data = '0;
    logic [31:0] m_pc = '0;
    logic [15:0] m_dc = '0;
    logic        m_err = 1'b0;
    logic        m_fd = 1'b0;

    function automatic void decode(input logic [31:0] a, output bit ok, output logic [16:0] idx);
        logic [31:0] o;
        int row, col;
        o   = a - 32'h0000_0000;
        row = int'(o / 1024);
        col = int'((o / 2) % 512);
        ok  = (o % 2 == 0) && (o < 32'h0004_0000) && (col < H) && (row < V);
        idx = 17'(row * H + col);
    endfunction

    always @(posedge clock) begin : model
        bit          hs, acc, ok;
        logic [16:0] idx;
        if (reset) begin
            mq.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0;
            m_pc = '0; m_dc = '0; m_err = 1'b0; m_fd = 1'b0;
        end else begin
            hs  = m_we && fb_ready;
            acc = s_write && (mq.size() < DEPTH);
            decode(s_address, ok, idx);
            m_fd = hs && (m_addr == 17'(H * V - 1));
            if (clear) begin
                m_pc = '0; m_dc = '0; m_err = 1'b0;
            end else begin
                if (hs) m_pc = m_pc + 32'd1;
                if (acc && !ok) begin
                    m_err = 1'b1;
                    if (m_dc != 16'hFFFF) m_dc = m_dc + 16'd1;
                end
            end
            if (!m_we || hs) begin
                if (mq.size() > 0) begin
                    {m_addr, m_data} = mq.pop_front();
                    m_we = 1'b1;
                end else begin
                    m_we = 1'b0;
                end
            end
            if (acc && ok) mq.push_back({idx, s_writedata});
        end
    end

    // Per-cycle comparison against the model, plus a log of fb handshakes.
    logic [32:0] obs[$];
    int          we_cycles = 0;

    always @(negedge clock) begin
        chk("waitrequest", 64'(s_waitrequest), 64'(reset | (mq.size() == DEPTH)));
        chk("fb_we", 64'(fb_we), 64'(m_we));
        if (m_we) begin
            chk("fb_addr", 64'(fb_addr), 64'(m_addr));
            chk("fb_data", 64'(fb_data), 64'(m_data));
        end
        chk("pixel_count", 64'(pixel_count), 64'(m_pc));
        chk("drop_count", 64'(drop_count), 64'(m_dc));
        chk("error", 64'(error), 64'(m_err));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
        if (fb_we && fb_ready) obs.push_back({fb_addr, fb_data});
        if (fb_we) we_cycles++;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one write and hold it until accepted (bounded).
    task automatic wr(input logic [31:0] a, input logic [15:0] d);
        bit done;
        done        = 1'b0;
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!s_waitrequest) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL write_accept_timeout: addr %0h not accepted, required acceptance", a);
        end
        step();
        s_write = 1'b0;
    endtask

    function automatic logic [31:0] pa(input int r, input int c);
        return 32'((r << 10) | (c << 1));
    endfunction

    initial begin
        int  base;
        bit  seen;
        reset = 1'b1; s_write = 1'b0; s_address = '0; s_writedata = '0;
        fb_ready = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("lit_wait_in_reset", 64'(s_waitrequest), 64'(1));
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("lit_rst_fb_we", 64'(fb_we), 64'(0));
        chk("lit_rst_pixel_count", 64'(pixel_count), 64'(0));
        chk("lit_rst_waitrequest", 64'(s_waitrequest), 64'(0));
        chk("lit_rst_error", 64'(error), 64'(0));

        // Single pixel at row 1, col 2.
        step();
        fb_ready = 1'b1;
        wr(32'h404, 16'hBEEF);
        repeat (5) step();
        chk("lit_t1_obs_count", 64'(obs.size()), 64'(1));
        chk("lit_t1_pixel", 64'(obs[0]), 64'({17'd322, 16'hBEEF}));
        chk("lit_t1_we_cycles", 64'(we_cycles), 64'(1));
        chk("lit_t1_pixel_count", 64'(pixel_count), 64'(1));
        chk("lit_t1_error", 64'(error), 64'(0));

        // Backpressure: one pixel sits on the bus, four fill the FIFO, the sixth stalls.
        fb_ready = 1'b0;
        base = obs.size();
        for (int i = 0; i < 5; i++) wr(pa(10, i * 3), 16'h1000 + 16'(i));
        s_address = pa(10, 15); s_writedata = 16'h1005; s_write = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("lit_t2_stall", 64'(s_waitrequest), 64'(1));
        end
        step();
        fb_ready = 1'b1;
        wr(pa(10, 15), 16'h1005);
        repeat (12) step();
        chk("lit_t2_obs_count", 64'(obs.size() - base), 64'(6));
        chk("lit_t2_first", 64'(obs[base]), 64'({17'd3200, 16'h1000}));
        chk("lit_t2_last", 64'(obs[base+5]), 64'({17'd3215, 16'h1005}));
        chk("lit_t2_pixel_count", 64'(pixel_count), 64'(7));

        // Rejected writes: column 320, odd address, row 240.
        base = obs.size();
        wr(32'h280, 16'h1111);
        wr(32'h3, 16'h2222);
        wr(32'(240 << 10), 16'h3333);
        repeat (5) step();
        chk("lit_t3_no_fb", 64'(obs.size() - base), 64'(0));
        chk("lit_t3_drop_count", 64'(drop_count), 64'(3));
        chk("lit_t3_error", 64'(error), 64'(1));

        // Last pixel of the frame: row 239, col 319.
        wr(32'h3BE7E, 16'hCAFE);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fb_we && fb_ready && fb_addr == 17'd76799) begin
                seen = 1'b1;
                break;
            end
        end
        chk("lit_t4_last_pixel_seen", 64'(seen), 64'(1));
        @(negedge clock);
        chk("lit_t4_frame_done_pulse", 64'(frame_done), 64'(1));
        @(negedge clock);
        chk("lit_t4_frame_done_end", 64'(frame_done), 64'(0));
        step();

        // Clear coinciding with a rejected write.
        clear = 1'b1;
        wr(32'h3, 16'h4444);
        clear = 1'b0;
        chk("lit_t5_drop_count", 64'(drop_count), 64'(0));
        chk("lit_t5_error", 64'(error), 64'(0));
        chk("lit_t5_pixel_count", 64'(pixel_count), 64'(0));

        // Reset with pixels buffered and the framebuffer stalled.
        wr(pa(3, 3), 16'h5555);
        repeat (5) step();
        chk("lit_t6_pre_count", 64'(pixel_count), 64'(1));
        fb_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(pa(5, i), 16'h6000 + 16'(i));
        base = obs.size();
        step();
        reset = 1'b1;
        step();
        chk("lit_t6_fb_we_after_reset", 64'(fb_we), 64'(0));
        chk("lit_t6_pixel_count", 64'(pixel_count), 64'(0));
        reset = 1'b0;
        fb_ready = 1'b1;
        repeat (10) step();
        chk("lit_t6_no_fb", 64'(obs.size() - base), 64'(0));
        chk("lit_t6_waitrequest", 64'(s_waitrequest), 64'(0));
        chk("lit_t6_fb_we_idle", 64'(fb_we), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
